// File: rtl/seq_arb_4in_rr_req_ctrl.sv
// ---------------------------------------------------------------------------------------------
// seq_arb_4in_rr_req_ctrl
//
// Request-side controller for a 4-input variable-priority sequential arbiter. It keeps a
// saturating count of outstanding requests per requester, presents reqs to the arbiter,
// retires one request per legal grant, and feeds the arbiter a rotated one-hot priority
// after every legal grant so that arbitration becomes round-robin. With rr_en low the
// arbiter's priority is never reloaded, so it keeps whatever priority it already holds.
//
// Ports:
//   clk              clock
//   reset            synchronous active-high reset
//   push[3:0]        push[i] adds one pending request for requester i
//   rr_en            1 = reload arbiter priority after each grant
//   grants[3:0]      grant vector from the arbiter (combinational, same cycle)
//   reqs[3:0]        request vector to the arbiter, reqs[i] = (count[i] != 0)
//   set_priority_en  priority-load strobe to the arbiter
//   set_priority     one-hot priority value to the arbiter (0001 when not loading)
//   full[3:0]        full[i] = (count[i] == MAX_PENDING)
//   count_flat       {count3, count2, count1, count0}
//   overflow         sticky: a push was dropped because the counter was full
//   proto_err        sticky: an illegal grant (multi-hot or unrequested) was observed
// ---------------------------------------------------------------------------------------------
module seq_arb_4in_rr_req_ctrl #(
  parameter  int unsigned MAX_PENDING = 3,
  localparam int unsigned CW          = $clog2(MAX_PENDING + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      push,
  input  logic            rr_en,
  input  logic [3:0]      grants,
  output logic [3:0]      reqs,
  output logic            set_priority_en,
  output logic [3:0]      set_priority,
  output logic [3:0]      full,
  output logic [4*CW-1:0] count_flat,
  output logic            overflow,
  output logic            proto_err
);

  localparam logic [CW-1:0] MaxCnt = CW'(MAX_PENDING);
  localparam logic [CW-1:0] OneCnt = CW'(1);

  // Registered state
  logic [CW-1:0] r_count [4];
  logic          r_overflow;
  logic          r_proto_err;

  // Combinational decode
  logic [CW-1:0] w_count_nxt [4];
  logic [3:0]    w_reqs;
  logic [3:0]    w_full;
  logic [3:0]    w_dec;
  logic [3:0]    w_drop;
  logic          w_grant_any;
  logic          w_grant_onehot;
  logic          w_grant_valid;
  logic          w_grant_illegal;

  // Request / full decode of the registered counts. reqs never depends on grants, which
  // keeps the arbiter loop free of combinational cycles.
  always_comb begin
    w_reqs     = '0;
    w_full     = '0;
    count_flat = '0;
    for (int i = 0; i < 4; i++) begin
      w_reqs[i]               = (r_count[i] != '0);
      w_full[i]               = (r_count[i] == MaxCnt);
      count_flat[i*CW +: CW]  = r_count[i];
    end
  end

  // Grant qualification: exactly one bit set, and that requester actually has work pending.
  always_comb begin
    w_grant_any     = (grants != 4'b0000);
    w_grant_onehot  = w_grant_any && ((grants & (grants - 4'b0001)) == 4'b0000);
    w_grant_valid   = w_grant_onehot && ((grants & ~w_reqs) == 4'b0000);
    w_grant_illegal = w_grant_any && !w_grant_valid;
    w_dec           = w_grant_valid ? grants : 4'b0000;
  end

  // Per-requester counter next state. A simultaneous push and retire cancel out, even when
  // full, so that case is never treated as an overflow.
  always_comb begin
    w_drop = '0;
    for (int i = 0; i < 4; i++) begin
      w_count_nxt[i] = r_count[i];
      unique case ({push[i], w_dec[i]})
        2'b10: begin
          if (w_full[i]) begin
            w_drop[i] = 1'b1;
          end else begin
            w_count_nxt[i] = r_count[i] + OneCnt;
          end
        end
        // w_dec only fires when reqs[i] is set, so the count is non-zero here.
        2'b01:   w_count_nxt[i] = r_count[i] - OneCnt;
        default: w_count_nxt[i] = r_count[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_count[i] <= '0;
      end
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_count[i] <= w_count_nxt[i];
      end
      r_overflow  <= r_overflow  | (|w_drop);
      r_proto_err <= r_proto_err | w_grant_illegal;
    end
  end

  // Round-robin priority: the requester after the winner becomes highest priority. The
  // arbiter loads it on the same edge that retires the granted request.
  always_comb begin
    set_priority_en = w_grant_valid & rr_en;
    set_priority    = 4'b0001;
    if (set_priority_en) begin
      set_priority = {grants[2:0], grants[3]};
    end
  end

  assign reqs      = w_reqs;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign proto_err = r_proto_err;

  // Sanity properties on the implementation
  a_prio_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot(set_priority));
  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    (r_count[0] <= MaxCnt) && (r_count[1] <= MaxCnt) &&
    (r_count[2] <= MaxCnt) && (r_count[3] <= MaxCnt));
  a_dec_only_pending : assert property (@(posedge clk) disable iff (reset)
    ((w_dec & ~w_reqs) == 4'b0000));

endmodule

// File: tb/tb_seq_arb_4in_rr_req_ctrl.sv
module tb_seq_arb_4in_rr_req_ctrl;

  localparam int unsigned MAX_PENDING = 3;
  localparam int unsigned CW          = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      push;
  logic            rr_en;
  logic [3:0]      grants;
  logic [3:0]      reqs;
  logic            set_priority_en;
  logic [3:0]      set_priority;
  logic [3:0]      full;
  logic [4*CW-1:0] count_flat;
  logic            overflow;
  logic            proto_err;

  // Bench-side arbiter model
  logic            arb_en;
  logic [3:0]      forced_grants;
  logic [3:0]      arb_prio;
  logic [3:0]      arb_grants;

  int checks   = 0;
  int failures = 0;

  seq_arb_4in_rr_req_ctrl #(
    .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .rr_en          (rr_en),
    .grants         (grants),
    .reqs           (reqs),
    .set_priority_en(set_priority_en),
    .set_priority   (set_priority),
    .full           (full),
    .count_flat     (count_flat),
    .overflow       (overflow),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  // Variable-priority arbiter: search circularly starting at the one-hot priority bit.
  function automatic logic [3:0] arb_pick(input logic [3:0] r, input logic [3:0] p);
    int start;
    logic [3:0] g;
    start = 0;
    g     = 4'b0000;
    for (int i = 0; i < 4; i++) if (p[i]) start = i;
    for (int k = 0; k < 4; k++) begin
      if (g == 4'b0000 && r[(start + k) % 4]) g = 4'b0001 << ((start + k) % 4);
    end
    return g;
  endfunction

  always_comb arb_grants = arb_pick(reqs, arb_prio);
  assign grants = arb_en ? arb_grants : forced_grants;

  always_ff @(posedge clk) begin
    if (reset)                arb_prio <= 4'b0001;
    else if (set_priority_en) arb_prio <= set_priority;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    push          = 4'b0000;
    rr_en         = 1'b1;
    arb_en        = 1'b0;
    forced_grants = 4'b0000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    push          = 4'b0000;
    rr_en         = 1'b1;
    arb_en        = 1'b0;
    forced_grants = 4'b0000;
    step();
    step();
    checks++; if (reqs !== 4'b0000) begin failures++;
      $display("FAIL reset_reqs: got %b expected %b", reqs, 4'b0000); end
    checks++; if (full !== 4'b0000) begin failures++;
      $display("FAIL reset_full: got %b expected %b", full, 4'b0000); end
    checks++; if (count_flat !== 8'h00) begin failures++;
      $display("FAIL reset_counts: got %h expected %h", count_flat, 8'h00); end
    checks++; if (set_priority_en !== 1'b0) begin failures++;
      $display("FAIL reset_spe: got %b expected %b", set_priority_en, 1'b0); end
    checks++; if (set_priority !== 4'b0001) begin failures++;
      $display("FAIL reset_sp: got %b expected %b", set_priority, 4'b0001); end
    checks++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin failures++;
      $display("FAIL reset_flags: got ovf=%b perr=%b expected 0 0", overflow, proto_err); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    arb_en = 1'b1;
    push   = 4'b0001;
    step();
    push = 4'b0000;
    #1;
    checks++; if (reqs !== 4'b0001) begin failures++;
      $display("FAIL single_reqs: got %b expected %b", reqs, 4'b0001); end
    checks++; if (grants !== 4'b0001) begin failures++;
      $display("FAIL single_grant: got %b expected %b", grants, 4'b0001); end
    checks++; if (set_priority_en !== 1'b1) begin failures++;
      $display("FAIL single_spe: got %b expected %b", set_priority_en, 1'b1); end
    checks++; if (set_priority !== 4'b0010) begin failures++;
      $display("FAIL single_sp: got %b expected %b", set_priority, 4'b0010); end
    step();
    checks++; if (reqs !== 4'b0000) begin failures++;
      $display("FAIL single_reqs_after: got %b expected %b", reqs, 4'b0000); end
    checks++; if (count_flat !== 8'h00) begin failures++;
      $display("FAIL single_count_after: got %h expected %h", count_flat, 8'h00); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    arb_en = 1'b1;
    push   = 4'b1111;
    step();
    push = 4'b0000;
    #1;
    checks++; if (count_flat !== 8'h55) begin failures++;
      $display("FAIL rr_counts: got %h expected %h", count_flat, 8'h55); end
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      checks++; if (grants !== exp_g) begin failures++;
        $display("FAIL rr_grant%0d: got %b expected %b", k, grants, exp_g); end
      step();
    end
    checks++; if (reqs !== 4'b0000) begin failures++;
      $display("FAIL rr_reqs_end: got %b expected %b", reqs, 4'b0000); end
    checks++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin failures++;
      $display("FAIL rr_flags: got ovf=%b perr=%b expected 0 0", overflow, proto_err); end
  endtask

  task automatic test_overflow();
    do_reset();
    push = 4'b0100;
    repeat (3) step();
    checks++; if (count_flat !== 8'h30) begin failures++;
      $display("FAIL ovf_count_sat: got %h expected %h", count_flat, 8'h30); end
    checks++; if (full !== 4'b0100) begin failures++;
      $display("FAIL ovf_full: got %b expected %b", full, 4'b0100); end
    checks++; if (overflow !== 1'b0) begin failures++;
      $display("FAIL ovf_early: got %b expected %b", overflow, 1'b0); end
    step();
    push = 4'b0000;
    checks++; if (overflow !== 1'b1) begin failures++;
      $display("FAIL ovf_set: got %b expected %b", overflow, 1'b1); end
    checks++; if (count_flat !== 8'h30) begin failures++;
      $display("FAIL ovf_count_hold: got %h expected %h", count_flat, 8'h30); end
    repeat (3) step();
    checks++; if (overflow !== 1'b1) begin failures++;
      $display("FAIL ovf_sticky: got %b expected %b", overflow, 1'b1); end
  endtask

  task automatic test_full_push_dec();
    do_reset();
    push = 4'b0010;
    repeat (3) step();
    forced_grants = 4'b0010;
    #1;
    checks++; if (set_priority_en !== 1'b1) begin failures++;
      $display("FAIL fpd_spe: got %b expected %b", set_priority_en, 1'b1); end
    checks++; if (set_priority !== 4'b0100) begin failures++;
      $display("FAIL fpd_sp: got %b expected %b", set_priority, 4'b0100); end
    step();
    push          = 4'b0000;
    forced_grants = 4'b0000;
    #1;
    checks++; if (count_flat !== 8'h0C) begin failures++;
      $display("FAIL fpd_count: got %h expected %h", count_flat, 8'h0C); end
    checks++; if (overflow !== 1'b0) begin failures++;
      $display("FAIL fpd_overflow: got %b expected %b", overflow, 1'b0); end
    checks++; if (full !== 4'b0010) begin failures++;
      $display("FAIL fpd_full: got %b expected %b", full, 4'b0010); end
  endtask

  // Relies on count1 = 3 left by test_full_push_dec.
  task automatic test_illegal_grant();
    forced_grants = 4'b0011;
    #1;
    checks++; if (set_priority_en !== 1'b0 || set_priority !== 4'b0001) begin failures++;
      $display("FAIL ill_multi_prio: got en=%b sp=%b expected 0 0001",
               set_priority_en, set_priority); end
    step();
    forced_grants = 4'b0000;
    #1;
    checks++; if (proto_err !== 1'b1) begin failures++;
      $display("FAIL ill_multi_perr: got %b expected %b", proto_err, 1'b1); end
    checks++; if (count_flat !== 8'h0C) begin failures++;
      $display("FAIL ill_multi_count: got %h expected %h", count_flat, 8'h0C); end
    do_reset();
    push = 4'b0001;
    step();
    push          = 4'b0000;
    forced_grants = 4'b1000;
    #1;
    checks++; if (set_priority_en !== 1'b0) begin failures++;
      $display("FAIL ill_unreq_spe: got %b expected %b", set_priority_en, 1'b0); end
    step();
    forced_grants = 4'b0000;
    #1;
    checks++; if (proto_err !== 1'b1) begin failures++;
      $display("FAIL ill_unreq_perr: got %b expected %b", proto_err, 1'b1); end
    checks++; if (count_flat !== 8'h01) begin failures++;
      $display("FAIL ill_unreq_count: got %h expected %h", count_flat, 8'h01); end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0001;
    exp_g[2] = 4'b0010;
    exp_g[3] = 4'b0010;
    do_reset();
    arb_en = 1'b1;
    rr_en  = 1'b0;
    push   = 4'b0011;
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (grants !== exp_g[k]) begin failures++;
        $display("FAIL fix_grant%0d: got %b expected %b", k, grants, exp_g[k]); end
      checks++; if (set_priority_en !== 1'b0) begin failures++;
        $display("FAIL fix_spe%0d: got %b expected %b", k, set_priority_en, 1'b0); end
      step();
      push = 4'b0000;
    end
    checks++; if (reqs !== 4'b0000) begin failures++;
      $display("FAIL fix_reqs_end: got %b expected %b", reqs, 4'b0000); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    arb_en = 1'b1;
    rr_en  = 1'b0;
    push   = 4'b0011;
    step();
    step();
    push = 4'b0000;
    #1;
    checks++; if (count_flat !== 8'h09) begin failures++;
      $display("FAIL mid_pre_count: got %h expected %h", count_flat, 8'h09); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (count_flat !== 8'h00) begin failures++;
      $display("FAIL mid_count: got %h expected %h", count_flat, 8'h00); end
    checks++; if (reqs !== 4'b0000) begin failures++;
      $display("FAIL mid_reqs: got %b expected %b", reqs, 4'b0000); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_full_push_dec();
    test_illegal_grant();
    test_fixed_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_arb_4in_rr_req_ctrl.md
Name: seq_arb_4in_rr_req_ctrl

Overview:
- Request-side controller that sits directly upstream of the 4-input variable-priority sequential arbiter and closes the loop around it.
- Holds a per-requester count of outstanding requests and drives `reqs` to the arbiter.
- Consumes the arbiter's `grants` to retire requests.
- Drives `set_priority_en`/`set_priority` so that the arbiter performs round-robin arbitration; when round-robin is disabled, the arbiter's priority is left unchanged.

Parameters:
- MAX_PENDING, 3, maximum outstanding requests per requester (≥1).
- CW, $clog2(MAX_PENDING+1), counter width (derived, not overridden).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- push  input  4  push[i]=1 adds one pending request for requester i this cycle
- rr_en  input  1  1 = rotate arbiter priority after each grant; 0 = leave arbiter priority unchanged
- grants  input  4  grant vector from the arbiter (combinational, same cycle)
- reqs  output  4  request vector to the arbiter
- set_priority_en  output  1  priority-load strobe to the arbiter
- set_priority  output  4  one-hot priority value to the arbiter
- full  output  4  full[i]=1 when count[i]==MAX_PENDING
- count_flat  output  4*CW  {count3,count2,count1,count0}
- overflow  output  1  sticky: a push was dropped
- proto_err  output  1  sticky: an illegal grant was observed

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`; all state updates happen on the posedge of `clk`.
- Reset values:
  - all counts = 0
  - overflow = 0
  - proto_err = 0
  - reqs = 0000, full = 0000, set_priority_en = 0, set_priority = 0001
- Reset takes priority over all other inputs.
- Reset asserted mid-operation clears all pending counts with no further grants consumed.
- reqs[i] = (count[i] != 0). This is a combinational decode of registered state, so it changes no earlier than the cycle after a push.
- Legal grant (gv): grants is one-hot and reqs at that bit position is 1. Call the granted index g.
- Illegal grant: grants ≠ 0000 and not gv, i.e. multi-hot, or the bit is set where reqs is 0.
  - Illegal grants are ignored: no decrement, no priority update.
  - proto_err is set and stays set until reset.
- Per-requester counter update each cycle, with dec = gv && g==i:
  - push[i] & !dec → count+1 if count<MAX_PENDING; otherwise count unchanged, the push is dropped and overflow is set (sticky).
  - dec & !push[i] → count−1.
  - push[i] & dec → count unchanged. This applies even when full: the push is accepted and no overflow is raised.
  - Neither push nor dec → count holds.
- Pushes to different requesters in the same cycle are all processed independently.
- Priority output (combinational, same cycle as the grant):
  - set_priority_en = gv & rr_en.
  - set_priority = grants rotated left by 1 with wrap-around: 0001→0010, 0010→0100, 0100→1000, 1000→0001.
  - When set_priority_en=0, set_priority drives 0001.
- The arbiter registers the new priority at the same clock edge at which the count decrements. The next cycle's arbitration therefore starts from the requester after the last winner.
- No combinational loop: grants depend on the arbiter's registered priority and on reqs, and reqs come from registered counts.
- Latency: a push in cycle t gives reqs[i]=1 in cycle t+1.
- Throughput: one grant per cycle.
- With rr_en=0, the arbiter keeps whatever priority it already holds (fixed priority), and counts still retire on grants.
- full[i] and count_flat are decodes of the registered counts.

Test Plan:
- Reset, then push=0001 for one cycle, with the bench modelling the arbiter at priority 0001.
  - Cycle+1: reqs=0001, grants=0001.
  - Cycle+1 outputs: set_priority_en=1, set_priority=0010.
  - Cycle+2: reqs=0000, count0=0.
- Push=1111 in one cycle, rr_en=1, arbiter in the loop.
  - Grants over the next four cycles are 0001, 0010, 0100, 1000.
  - reqs ends at 0000.
  - No overflow, no proto_err.
- Push[2] four times with MAX_PENDING=3 and no grants.
  - count2 saturates at 3 and full=0100.
  - The 4th push is dropped and overflow=1.
  - overflow stays 1 until reset.
- count1=3 (full), push[1] in the same cycle as grants=0010.
  - count1 stays 3 and overflow stays 0.
  - set_priority=0100.
- Drive illegal grants directly: grants=0011, and separately grants=1000 while reqs[3]=0.
  - proto_err=1, counts unchanged, set_priority_en=0.
- rr_en=0, push=0011 twice, arbiter at priority 0001.
  - Grants are 0001, 0001, 0010, 0010.
  - set_priority_en=0 throughout.
  - Asserting reset mid-sequence zeroes all counts next cycle and gives reqs=0000.
